ysyx_22050710_axil_sram_slave: RTL and testbench
================================================

YSYX_22050710_AXIL_SRAM_SLAVE -- requirements
Module: ysyx_22050710_axil_sram_slave

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as in the codebase: i_aclk and i_arsetn.
REQ-002 SHALL take parameter SRAM_ADDR_WD, default 32: AXI address width.
REQ-003 SHALL take parameter SRAM_DATA_WD, default 64: data width.
REQ-004 SHALL take parameter STRB_WIDTH, default SRAM_DATA_WD/8: write-strobe width.
REQ-005 SHALL take parameter MEM_BASE, default 32'h8000_0000: first byte address of the memory.
REQ-006 SHALL take parameter MEM_WORDS, default 4096: depth of the memory in data words.
REQ-007 SHALL take parameter RD_LAT, default 1, legal range 0..15: number of wait cycles before read data.
REQ-008 SHALL take parameter WR_LAT, default 1, legal range 0..15: number of wait cycles before the write response.
REQ-009 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
 - i_aclk, in, 1: clock.
 - i_arsetn, in, 1: asynchronous active-low reset.
 - i_awvalid, in, 1; o_awready, out, 1; i_awaddr, in, SRAM_ADDR_WD; i_awprot, in, 3 (ignored): write-address channel.
 - i_wvalid, in, 1; o_wready, out, 1; i_wdata, in, SRAM_DATA_WD; i_wstrb, in, STRB_WIDTH: write-data channel.
 - o_bvalid, out, 1; i_bready, in, 1; o_bresp, out, 2: write-response channel.
 - i_arvalid, in, 1; o_arready, out, 1; i_araddr, in, SRAM_ADDR_WD; i_arprot, in, 3 (ignored): read-address channel.
 - o_rvalid, out, 1; i_rready, in, 1; o_rdata, out, SRAM_DATA_WD; o_rresp, out, 2: read-data channel.

Function
REQ-010 SHALL implement an AXI4-Lite responder with independent read and write FSMs that run concurrently, one outstanding transaction per direction.
REQ-011 The write FSM SHALL have states W_IDLE, W_WAIT and W_RESP.
REQ-012 In W_IDLE, AW and W SHALL be accepted in either order or in the same cycle.
 - Each channel's ready SHALL be 1 until that channel has handshaked, then 0.
 - Address, data and strobe SHALL be latched at their handshakes.
REQ-013 When both AW and W have been captured, the write FSM SHALL go to W_WAIT and count WR_LAT cycles (WR_LAT=0 means zero cycles).
REQ-014 At the end of W_WAIT:
 - the write SHALL be committed to memory, byte lanes enabled by wstrb;
 - the FSM SHALL go to W_RESP with bvalid=1.
REQ-015 bvalid SHALL stay 1, with bresp held stable, until the cycle in which i_bready=1; the FSM SHALL then return to W_IDLE.
REQ-016 The read FSM SHALL have states R_IDLE, R_WAIT and R_DATA.
REQ-017 arready SHALL be 1 only in R_IDLE; on the AR handshake the address SHALL be latched and the FSM SHALL go to R_WAIT.
REQ-018 After RD_LAT cycles in R_WAIT, memory SHALL be sampled into o_rdata and the FSM SHALL go to R_DATA with rvalid=1.
REQ-019 rdata and rresp SHALL be held stable until the rready handshake; the FSM SHALL then return to R_IDLE.
REQ-020 Word index SHALL be (addr - MEM_BASE) >> log2(STRB_WIDTH); the low address bits SHALL be ignored.
REQ-021 An address below MEM_BASE, or at or above MEM_BASE + MEM_WORDS*STRB_WIDTH, SHALL produce resp=2'b10 (SLVERR).
 - A write to such an address SHALL be discarded.
 - A read from such an address SHALL return rdata=0.
REQ-022 An in-range access SHALL produce resp=2'b00 (OKAY); wstrb=0 SHALL produce OKAY with no change to memory.
REQ-023 When a write commit and a read sample hit the same word in the same cycle, the read SHALL return the pre-write data.
REQ-024 No valid SHALL depend combinationally on any ready input; all outputs SHALL be registered or decoded from state.

Reset
REQ-025 While i_arsetn=0, every output SHALL be 0: all readies, all valids, bresp, rresp and rdata.
REQ-026 Both FSMs SHALL reset to their IDLE state, and latency counters and capture flags SHALL reset to 0.
REQ-027 Readies SHALL first assert in the first cycle after i_arsetn deasserts.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no response.
 - A write not yet committed SHALL NOT modify memory.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 The shared package/header SHALL hold the response codes RESP_OKAY and RESP_SLVERR and the state encodings for both FSMs.
REQ-031 The design SHALL have one sub-module, ysyx_22050710_strb_mem.
 - It SHALL contain a byte-strobed synchronous array with one read port and one write port.
 - Its read-before-write behaviour SHALL satisfy REQ-023.

Verification
REQ-032 A bench SHALL cover: AW and W in the same cycle, addr 0x8000_0010, data 0x1122334455667788, strb 0xFF -> one bvalid after WR_LAT+1 cycles with bresp 0; a following read returns 0x1122334455667788 with rresp 0.
REQ-033 A bench SHALL cover: W three cycles before AW, then strb 0x0F with data 0xAAAAAAAAAAAAAAAA over the value 0x1122334455667788 -> read returns 0x11223344AAAAAAAA.
REQ-034 A bench SHALL cover: read of 0x7FFF_FFF8, then write to MEM_BASE+MEM_WORDS*8 -> rresp 2'b10 with rdata 0, bresp 2'b10, and memory unchanged.
REQ-035 A bench SHALL cover: rready held at 0 for 5 cycles, then bready held at 0 for 5 cycles -> rvalid, rdata, bvalid and bresp all held stable, and no new AR or AW accepted meanwhile.
REQ-036 A bench SHALL cover: a write and a read to the same word committing and sampling in the same cycle -> read returns old data; a next read returns new data.
REQ-037 A bench SHALL cover: reset asserted during W_WAIT -> all outputs 0, memory word unchanged, and readies return to 1 one cycle after release.

Source files
------------

// File: rtl/ysyx_22050710_axil_sram_slave_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes and
// the state encodings of its independent read and write FSMs.
package ysyx_22050710_axil_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Latency counters only need to reach the largest legal RD_LAT/WR_LAT (15).
    localparam int LAT_CNT_WD = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    function automatic logic [1:0] resp_of(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/ysyx_22050710_strb_mem.sv
// Byte-strobed simple dual-port RAM with a registered read port. A read and a
// write to the same word on the same edge return the word's previous contents.
module ysyx_22050710_strb_mem #(
    parameter int DATA_WD = 64,
    parameter int STRB_WD = DATA_WD / 8,
    parameter int DEPTH   = 4096,
    parameter int IDX_WD  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_WD-1:0]  waddr,
    input  logic [DATA_WD-1:0] wdata,
    input  logic [STRB_WD-1:0] wstrb,
    input  logic               re,
    input  logic [IDX_WD-1:0]  raddr,
    output logic [DATA_WD-1:0] rdata
);

    // One 8-bit array per lane so each strobe bit maps onto its own RAM column.
    for (genvar gi = 0; gi < STRB_WD; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rdata_reg;

        always_ff @(posedge clk) begin
            if (we && wstrb[gi]) begin
                lane_mem[waddr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
                lane_rdata_reg <= lane_mem[raddr];
            end
        end

        assign rdata[gi*8 +: 8] = lane_rdata_reg;
    end

endmodule

// File: rtl/ysyx_22050710_axil_sram_slave.sv
// AXI4-Lite responder backed by a byte-strobed SRAM, with concurrent read and
// write FSMs and programmable read/write wait latencies.
module ysyx_22050710_axil_sram_slave
    import ysyx_22050710_axil_sram_slave_pkg::*;
#(
    parameter int                      SRAM_ADDR_WD = 32,
    parameter int                      SRAM_DATA_WD = 64,
    parameter int                      STRB_WIDTH   = SRAM_DATA_WD / 8,
    parameter logic [SRAM_ADDR_WD-1:0] MEM_BASE     = 32'h8000_0000,
    parameter int                      MEM_WORDS    = 4096,
    parameter int                      RD_LAT       = 1,
    parameter int                      WR_LAT       = 1
) (
    input  logic                    i_aclk,
    input  logic                    i_arsetn,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [SRAM_ADDR_WD-1:0] i_awaddr,
    input  logic [2:0]              i_awprot,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [SRAM_DATA_WD-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0]   i_wstrb,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [1:0]              o_bresp,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [SRAM_ADDR_WD-1:0] i_araddr,
    input  logic [2:0]              i_arprot,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [SRAM_DATA_WD-1:0] o_rdata,
    output logic [1:0]              o_rresp
);

    localparam int IDX_WD  = $clog2(MEM_WORDS);
    localparam int BYTE_SH = $clog2(STRB_WIDTH);
    localparam logic [SRAM_ADDR_WD-1:0] MEM_BYTES = SRAM_ADDR_WD'(MEM_WORDS * STRB_WIDTH);
    localparam logic [LAT_CNT_WD-1:0]   WR_LAT_C  = LAT_CNT_WD'(WR_LAT);
    localparam logic [LAT_CNT_WD-1:0]   RD_LAT_C  = LAT_CNT_WD'(RD_LAT);

    // Keeps every ready low during reset and for the edge that releases it.
    logic alive_reg;

    w_state_e                w_state_reg, w_state_next;
    logic                    aw_done_reg, aw_done_next;
    logic                    w_done_reg, w_done_next;
    logic [SRAM_ADDR_WD-1:0] waddr_reg, waddr_next;
    logic [SRAM_DATA_WD-1:0] wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0]   wstrb_reg, wstrb_next;
    logic [LAT_CNT_WD-1:0]   wcnt_reg, wcnt_next;
    logic [1:0]              bresp_reg, bresp_next;

    r_state_e                r_state_reg, r_state_next;
    logic [SRAM_ADDR_WD-1:0] raddr_reg, raddr_next;
    logic [LAT_CNT_WD-1:0]   rcnt_reg, rcnt_next;
    logic [1:0]              rresp_reg, rresp_next;

    logic                    aw_hs, w_hs, ar_hs;
    logic [SRAM_ADDR_WD-1:0] w_off, r_off;
    logic                    w_in_range, r_in_range;
    logic                    mem_we, mem_re;
    logic [SRAM_DATA_WD-1:0] mem_rdata;
    logic                    unused_prot;

    assign unused_prot = ^{i_awprot, i_arprot};

    assign aw_hs = i_awvalid && o_awready;
    assign w_hs  = i_wvalid && o_wready;
    assign ar_hs = i_arvalid && o_arready;

    // Offset wraps for addresses below the base, so the lower-bound test is separate.
    assign w_off      = waddr_reg - MEM_BASE;
    assign r_off      = raddr_reg - MEM_BASE;
    assign w_in_range = (waddr_reg >= MEM_BASE) && (w_off < MEM_BYTES);
    assign r_in_range = (raddr_reg >= MEM_BASE) && (r_off < MEM_BYTES);

    always_comb begin
        w_state_next = w_state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        wcnt_next    = wcnt_reg;
        bresp_next   = bresp_reg;
        mem_we       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs) begin
                    waddr_next   = i_awaddr;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    wdata_next  = i_wdata;
                    wstrb_next  = i_wstrb;
                    w_done_next = 1'b1;
                end
                if (aw_done_next && w_done_next) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    wcnt_next    = '0;
                    w_state_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wcnt_reg == WR_LAT_C) begin
                    mem_we       = w_in_range;
                    bresp_next   = resp_of(w_in_range);
                    w_state_next = W_RESP;
                end else begin
                    wcnt_next = wcnt_reg + 1'b1;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        raddr_next   = raddr_reg;
        rcnt_next    = rcnt_reg;
        rresp_next   = rresp_reg;
        mem_re       = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    raddr_next   = i_araddr;
                    rcnt_next    = '0;
                    r_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rcnt_reg == RD_LAT_C) begin
                    mem_re       = r_in_range;
                    rresp_next   = resp_of(r_in_range);
                    r_state_next = R_DATA;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            R_DATA: begin
                if (i_rready) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            alive_reg   <= 1'b0;
            w_state_reg <= W_IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            wcnt_reg    <= '0;
            bresp_reg   <= RESP_OKAY;
            r_state_reg <= R_IDLE;
            raddr_reg   <= '0;
            rcnt_reg    <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            alive_reg   <= 1'b1;
            w_state_reg <= w_state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            wcnt_reg    <= wcnt_next;
            bresp_reg   <= bresp_next;
            r_state_reg <= r_state_next;
            raddr_reg   <= raddr_next;
            rcnt_reg    <= rcnt_next;
            rresp_reg   <= rresp_next;
        end
    end

    ysyx_22050710_strb_mem #(
        .DATA_WD (SRAM_DATA_WD),
        .STRB_WD (STRB_WIDTH),
        .DEPTH   (MEM_WORDS),
        .IDX_WD  (IDX_WD)
    ) u_mem (
        .clk   (i_aclk),
        .we    (mem_we),
        .waddr (w_off[BYTE_SH +: IDX_WD]),
        .wdata (wdata_reg),
        .wstrb (wstrb_reg),
        .re    (mem_re),
        .raddr (r_off[BYTE_SH +: IDX_WD]),
        .rdata (mem_rdata)
    );

    assign o_awready = alive_reg && (w_state_reg == W_IDLE) && !aw_done_reg;
    assign o_wready  = alive_reg && (w_state_reg == W_IDLE) && !w_done_reg;
    assign o_bvalid  = (w_state_reg == W_RESP);
    assign o_bresp   = bresp_reg;
    assign o_arready = alive_reg && (r_state_reg == R_IDLE);
    assign o_rvalid  = (r_state_reg == R_DATA);
    assign o_rresp   = rresp_reg;
    // The RAM read register holds between reads, so rdata stays put until rready.
    assign o_rdata   = (r_state_reg == R_DATA && rresp_reg == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050710_axil_sram_slave.sv
// Scenario bench for the AXI4-Lite SRAM responder: expected responses are
// queued when stimulus is driven and popped when the DUT presents them.
module tb_ysyx_22050710_axil_sram_slave;

    localparam int RD_LAT = 1;
    localparam int WR_LAT = 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [1:0]  resp;
        logic [63:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_awvalid, i_wvalid, i_bready, i_arvalid, i_rready;
    logic [31:0] i_awaddr, i_araddr;
    logic [63:0] i_wdata;
    logic [7:0]  i_wstrb;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp, o_rresp;
    logic [63:0] o_rdata;

    int    checks = 0;
    int    passes = 0;
    rexp_t r_q[$];
    logic [1:0] b_q[$];

    always #5 clk = ~clk;

    ysyx_22050710_axil_sram_slave #(
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .i_aclk    (clk),
        .i_arsetn  (rst_n),
        .i_awvalid (i_awvalid),
        .o_awready (o_awready),
        .i_awaddr  (i_awaddr),
        .i_awprot  (3'b000),
        .i_wvalid  (i_wvalid),
        .o_wready  (o_wready),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .o_bvalid  (o_bvalid),
        .i_bready  (i_bready),
        .o_bresp   (o_bresp),
        .i_arvalid (i_arvalid),
        .o_arready (o_arready),
        .i_araddr  (i_araddr),
        .i_arprot  (3'b000),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready),
        .o_rdata   (o_rdata),
        .o_rresp   (o_rresp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1);
    end

    // ---------------- stimulus-only helpers ----------------
    task automatic write_txn(input logic [31:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, output bit ok);
        bit aw_done, w_done, aw_hs, w_hs;
        int t;
        aw_done = 0; w_done = 0; t = 0;
        i_awaddr = addr; i_wdata = data; i_wstrb = strb;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        while (!(aw_done && w_done) && t < 40) begin
            @(negedge clk);
            aw_hs = i_awvalid && o_awready;
            w_hs  = i_wvalid && o_wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; i_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  i_wvalid = 1'b0;  end
            t++;
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        ok = aw_done && w_done;
    endtask

    task automatic read_txn(input logic [31:0] addr, output bit ok);
        bit hs;
        ok = 0;
        i_araddr = addr; i_arvalid = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            hs = o_arready;
            @(posedge clk); #1;
            ok = hs;
        end
        i_arvalid = 1'b0;
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!o_bvalid && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_r(output int n);
        n = 0;
        while (!o_rvalid && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic accept_b();
        i_bready = 1'b1; @(posedge clk); #1; i_bready = 1'b0;
    endtask

    task automatic accept_r();
        i_rready = 1'b1; @(posedge clk); #1; i_rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_awvalid = 0; i_wvalid = 0; i_bready = 0; i_arvalid = 0; i_rready = 0;
        i_awaddr = '0; i_araddr = '0; i_wdata = '0; i_wstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_bresp, o_rresp, o_rdata} !== '0)
            $display("FAIL reset_outputs: got %h, want 0",
                     {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_bresp, o_rresp, o_rdata});
        else passes++;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if ({o_awready, o_wready, o_arready} !== 3'b000)
            $display("FAIL reset_release_early: readies=%b, want 000", {o_awready, o_wready, o_arready});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({o_awready, o_wready, o_arready} !== 3'b111)
            $display("FAIL reset_release_ready: readies=%b, want 111", {o_awready, o_wready, o_arready});
        else passes++;
        $display("reset: done");
    endtask

    task automatic test_same_cycle_write();
        bit ok; int n; logic [1:0] exp_b; rexp_t exp_r;
        b_q.push_back(OKAY);
        write_txn(32'h8000_0010, 64'h1122334455667788, 8'hFF, ok);
        wait_b(n);
        checks++;
        if (!ok || n != WR_LAT + 1)
            $display("FAIL same_cycle_blat: handshake=%0b bvalid after %0d, want 1 and %0d", ok, n, WR_LAT + 1);
        else passes++;
        exp_b = b_q.pop_front();
        checks++;
        if (o_bvalid !== 1'b1 || o_bresp !== exp_b)
            $display("FAIL same_cycle_bresp: bvalid=%b bresp=%b, want 1 %b", o_bvalid, o_bresp, exp_b);
        else passes++;
        accept_b();
        checks++;
        if (o_bvalid !== 1'b0) $display("FAIL same_cycle_bdrop: bvalid=%b, want 0", o_bvalid);
        else passes++;
        r_q.push_back({OKAY, 64'h1122334455667788});
        read_txn(32'h8000_0010, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        checks++;
        if (!ok || n != RD_LAT + 1)
            $display("FAIL same_cycle_rlat: handshake=%0b rvalid after %0d, want 1 and %0d", ok, n, RD_LAT + 1);
        else passes++;
        checks++;
        if (o_rvalid !== 1'b1 || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL same_cycle_rdata: got %b %h, want %h", o_rvalid, {o_rresp, o_rdata}, exp_r);
        else passes++;
        accept_r();
        $display("write 80000010 <= 1122334455667788 strb ff, read back: done");
    endtask

    task automatic test_w_before_aw();
        bit ok, hs; int n; logic [1:0] exp_b; rexp_t exp_r;
        b_q.push_back(OKAY);
        i_wdata = 64'hAAAA_AAAA_AAAA_AAAA; i_wstrb = 8'h0F; i_wvalid = 1'b1;
        @(negedge clk); hs = o_wready;
        @(posedge clk); #1; i_wvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (!hs || {o_awready, o_wready} !== 2'b10)
            $display("FAIL w_first_readies: whs=%0b aw/w ready=%b, want 1 10", hs, {o_awready, o_wready});
        else passes++;
        i_awaddr = 32'h8000_0010; i_awvalid = 1'b1;
        @(negedge clk); hs = o_awready;
        @(posedge clk); #1; i_awvalid = 1'b0;
        wait_b(n);
        exp_b = b_q.pop_front();
        checks++;
        if (!hs || n != WR_LAT + 1 || o_bresp !== exp_b)
            $display("FAIL w_first_bresp: awhs=%0b lat=%0d bresp=%b, want 1 %0d %b", hs, n, o_bresp, WR_LAT + 1, exp_b);
        else passes++;
        accept_b();
        r_q.push_back({OKAY, 64'h11223344AAAAAAAA});
        read_txn(32'h8000_0010, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        checks++;
        if (!ok || o_rvalid !== 1'b1 || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL w_first_rdata: got %b %h, want %h", o_rvalid, {o_rresp, o_rdata}, exp_r);
        else passes++;
        accept_r();
        $display("write W 3 cycles before AW, strb 0f: done");
    endtask

    task automatic test_out_of_range();
        bit ok; int n; logic [1:0] exp_b; rexp_t exp_r;
        b_q.push_back(OKAY);
        write_txn(32'h8000_0000, 64'hCAFEF00D01234567, 8'hFF, ok);
        wait_b(n);
        exp_b = b_q.pop_front();
        checks++;
        if (!ok || o_bvalid !== 1'b1 || o_bresp !== exp_b)
            $display("FAIL oor_base_write: bvalid=%b bresp=%b, want 1 %b", o_bvalid, o_bresp, exp_b);
        else passes++;
        accept_b();
        b_q.push_back(OKAY);
        write_txn(32'h8000_7FF8, 64'h0, 8'hFF, ok);
        wait_b(n);
        exp_b = b_q.pop_front();
        checks++;
        if (!ok || o_bvalid !== 1'b1 || o_bresp !== exp_b)
            $display("FAIL oor_last_word: bvalid=%b bresp=%b, want 1 %b", o_bvalid, o_bresp, exp_b);
        else passes++;
        accept_b();
        r_q.push_back({SLVERR, 64'h0});
        read_txn(32'h7FFF_FFF8, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        checks++;
        if (!ok || o_rvalid !== 1'b1 || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL oor_below_read: got %b %h, want %h", o_rvalid, {o_rresp, o_rdata}, exp_r);
        else passes++;
        accept_r();
        b_q.push_back(SLVERR);
        write_txn(32'h8000_8000, 64'hDEADBEEFDEADBEEF, 8'hFF, ok);
        wait_b(n);
        exp_b = b_q.pop_front();
        checks++;
        if (!ok || o_bvalid !== 1'b1 || o_bresp !== exp_b)
            $display("FAIL oor_above_write: bvalid=%b bresp=%b, want 1 %b", o_bvalid, o_bresp, exp_b);
        else passes++;
        accept_b();
        r_q.push_back({OKAY, 64'hCAFEF00D01234567});
        read_txn(32'h8000_0000, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        checks++;
        if (!ok || o_rvalid !== 1'b1 || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL oor_mem_unchanged: got %b %h, want %h", o_rvalid, {o_rresp, o_rdata}, exp_r);
        else passes++;
        accept_r();
        $display("out-of-range read 7ffffff8 and write 80008000: done");
    endtask

    task automatic test_backpressure();
        bit ok; int n; logic [1:0] exp_b; rexp_t exp_r;
        r_q.push_back({OKAY, 64'h11223344AAAAAAAA});
        read_txn(32'h8000_0010, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        i_araddr = 32'h8000_0000; i_arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_rvalid !== 1'b1 || o_arready !== 1'b0 || {o_rresp, o_rdata} !== exp_r)
                $display("FAIL r_hold_c%0d: rvalid=%b arready=%b data=%h, want 1 0 %h",
                         c, o_rvalid, o_arready, {o_rresp, o_rdata}, exp_r);
            else passes++;
            @(posedge clk);
        end
        #1; i_arvalid = 1'b0;
        accept_r();
        checks++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b1)
            $display("FAIL r_hold_release: rvalid=%b arready=%b, want 0 1", o_rvalid, o_arready);
        else passes++;
        b_q.push_back(OKAY);
        write_txn(32'h8000_0018, 64'h0F0F0F0F0F0F0F0F, 8'hFF, ok);
        wait_b(n);
        exp_b = b_q.pop_front();
        i_awaddr = 32'h8000_0028; i_wdata = 64'h1; i_awvalid = 1'b1; i_wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_bvalid !== 1'b1 || o_bresp !== exp_b || {o_awready, o_wready} !== 2'b00)
                $display("FAIL b_hold_c%0d: bvalid=%b bresp=%b aw/w ready=%b, want 1 %b 00",
                         c, o_bvalid, o_bresp, {o_awready, o_wready}, exp_b);
            else passes++;
            @(posedge clk);
        end
        #1; i_awvalid = 1'b0; i_wvalid = 1'b0;
        accept_b();
        checks++;
        if (o_bvalid !== 1'b0 || {o_awready, o_wready} !== 2'b11)
            $display("FAIL b_hold_release: bvalid=%b readies=%b, want 0 11", o_bvalid, {o_awready, o_wready});
        else passes++;
        $display("rready and bready held low 5 cycles: done");
    endtask

    task automatic test_collision();
        bit ok; int n; logic [2:0] hs; logic [1:0] exp_b; rexp_t exp_r;
        b_q.push_back(OKAY);
        write_txn(32'h8000_0020, 64'h0123456789ABCDEF, 8'hFF, ok);
        wait_b(n);
        exp_b = b_q.pop_front();
        accept_b();
        b_q.push_back(OKAY);
        r_q.push_back({OKAY, 64'h0123456789ABCDEF});
        i_awaddr = 32'h8000_0020; i_wdata = 64'hFEDCBA9876543210; i_wstrb = 8'hFF;
        i_araddr = 32'h8000_0020;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
        @(negedge clk); hs = {o_awready, o_wready, o_arready};
        @(posedge clk); #1;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
        wait_r(n);
        checks++;
        if (hs !== 3'b111 || {o_rvalid, o_bvalid} !== 2'b11)
            $display("FAIL collide_align: hs=%b r/b valid=%b, want 111 11", hs, {o_rvalid, o_bvalid});
        else passes++;
        exp_b = b_q.pop_front();
        exp_r = r_q.pop_front();
        checks++;
        if (o_bresp !== exp_b || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL collide_old_data: bresp=%b rdata=%h, want %b %h", o_bresp, {o_rresp, o_rdata}, exp_b, exp_r);
        else passes++;
        i_bready = 1'b1; i_rready = 1'b1;
        @(posedge clk); #1;
        i_bready = 1'b0; i_rready = 1'b0;
        r_q.push_back({OKAY, 64'hFEDCBA9876543210});
        read_txn(32'h8000_0020, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        checks++;
        if (!ok || o_rvalid !== 1'b1 || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL collide_new_data: got %b %h, want %h", o_rvalid, {o_rresp, o_rdata}, exp_r);
        else passes++;
        accept_r();
        $display("same-word write commit and read sample on one edge: done");
    endtask

    task automatic test_reset_mid_write();
        bit ok; int n; rexp_t exp_r;
        write_txn(32'h8000_0010, 64'h5555555555555555, 8'hFF, ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_bresp, o_rresp, o_rdata} !== '0)
            $display("FAIL midreset_outputs: hs=%0b got %h, want 0", ok,
                     {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_bresp, o_rresp, o_rdata});
        else passes++;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; #1;
        checks++;
        if ({o_awready, o_wready, o_arready} !== 3'b000)
            $display("FAIL midreset_early: readies=%b, want 000", {o_awready, o_wready, o_arready});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({o_awready, o_wready, o_arready} !== 3'b111)
            $display("FAIL midreset_ready: readies=%b, want 111", {o_awready, o_wready, o_arready});
        else passes++;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({o_bvalid, o_rvalid} !== 2'b00)
            $display("FAIL midreset_no_resp: b/r valid=%b, want 00", {o_bvalid, o_rvalid});
        else passes++;
        r_q.push_back({OKAY, 64'h11223344AAAAAAAA});
        read_txn(32'h8000_0010, ok);
        wait_r(n);
        exp_r = r_q.pop_front();
        checks++;
        if (!ok || o_rvalid !== 1'b1 || {o_rresp, o_rdata} !== exp_r)
            $display("FAIL midreset_mem: got %b %h, want %h", o_rvalid, {o_rresp, o_rdata}, exp_r);
        else passes++;
        accept_r();
        $display("reset during W_WAIT: done");
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
